// File: rtl/countdown_timer.sv
// Purpose : MM:SS countdown timer with load/start/stop/clear control and expiry pulse.
// Latency : every control input takes effect on the next clk edge; all outputs registered.
// Backpressure: none; pulses are consumed in the cycle they are seen (load > start/stop/tick).
// Optional feature: define TIMER_ALARM_EN for the latched alarm output (otherwise alarm = 0).
module countdown_timer #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [5:0] r_minute,
  output logic [5:0] r_second,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [5:0] MAX_MIN_W = 6'(MAX_MIN);
  localparam logic [5:0] MAX_SEC_W = 6'd59;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [5:0] w_min_nxt;
  logic [5:0] w_sec_nxt;
  logic [5:0] w_min_clamp;
  logic [5:0] w_sec_clamp;
  logic       w_zero;
  logic       w_last;
  logic       w_expire;

  assign w_min_clamp = (load_min > MAX_MIN_W) ? MAX_MIN_W : load_min;
  assign w_sec_clamp = (load_sec > MAX_SEC_W) ? MAX_SEC_W : load_sec;
  assign w_zero      = (r_minute == 6'd0) && (r_second == 6'd0);
  assign w_last      = (r_minute == 6'd0) && (r_second == 6'd1);
  // Entering EXPIRED from any other state is the single expiry event.
  assign w_expire    = (w_state_nxt == S_EXPIRED) && (r_state != S_EXPIRED);

  // Next state and count; load has priority over every other control input.
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_minute;
    w_sec_nxt   = r_second;
    if (load) begin
      w_min_nxt   = w_min_clamp;
      w_sec_nxt   = w_sec_clamp;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if (start) begin
            w_state_nxt = w_zero ? S_EXPIRED : S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            w_state_nxt = S_PAUSE;
          end else if (sec_tick && !w_zero) begin
            // Borrow from minutes when seconds are already at zero.
            if (r_second != 6'd0) begin
              w_sec_nxt = r_second - 6'd1;
            end else begin
              w_min_nxt = r_minute - 6'd1;
              w_sec_nxt = MAX_SEC_W;
            end
            if (w_last) begin
              w_state_nxt = S_EXPIRED;
            end
          end
        end
        S_EXPIRED: begin
          if (clear) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, count and status registers; reset wins over everything, never pulses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_minute <= 6'd0;
      r_second <= 6'd0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_minute <= w_min_nxt;
      r_second <= w_sec_nxt;
      running  <= (w_state_nxt == S_RUN);
      done     <= w_expire;
    end
  end

`ifdef TIMER_ALARM_EN
  // Alarm latches on expiry and is dropped by load or clear (expiry wins over clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm <= 1'b0;
    end else if (load) begin
      alarm <= 1'b0;
    end else if (w_expire) begin
      alarm <= 1'b1;
    end else if (clear) begin
      alarm <= 1'b0;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random control traffic,
// compared every cycle against a total-seconds reference model.
// Alarm expectations follow TIMER_ALARM_EN the same way the design build does.
module tb_countdown_timer;

  localparam int TB_MAX_MIN = 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tick = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_min = 6'd0;
  logic [5:0] load_sec = 6'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] r_minute;
  logic [5:0] r_second;
  logic       running;
  logic       done;
  logic       alarm;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining time as plain seconds.
  int m_total = 0;
  int m_mode  = M_IDLE;
  int m_done  = 0;
  int m_alarm = 0;

  countdown_timer #(.MAX_MIN(TB_MAX_MIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .r_minute (r_minute),
    .r_second (r_second),
    .running  (running),
    .done     (done),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance the model by one clock edge from the currently applied inputs.
  task automatic model_step();
    if (rst) begin
      m_total = 0; m_mode = M_IDLE; m_done = 0; m_alarm = 0;
    end else begin
      m_done = 0;
      if (load) begin
        m_total = 60 * imin(int'(load_min), TB_MAX_MIN) + imin(int'(load_sec), 59);
        m_mode  = M_IDLE;
        m_alarm = 0;
      end else begin
        if ((m_mode == M_IDLE || m_mode == M_PAUSE) && start) begin
          if (m_total == 0) begin m_mode = M_EXP; m_done = 1; end
          else m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
          if (stop) m_mode = M_PAUSE;
          else if (sec_tick && m_total > 0) begin
            m_total--;
            if (m_total == 0) begin m_mode = M_EXP; m_done = 1; end
          end
        end else if (m_mode == M_EXP && clear) begin
          m_mode = M_IDLE;
        end
`ifdef TIMER_ALARM_EN
        if (m_done == 1) m_alarm = 1;
        else if (clear) m_alarm = 0;
`endif
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, and compare all outputs to the model.
  task automatic cyc(input bit i_rst, input bit i_ld, input int lm, input int ls,
                     input bit i_st, input bit i_sp, input bit i_tk, input bit i_clr);
    rst = i_rst; load = i_ld; load_min = 6'(lm); load_sec = 6'(ls);
    start = i_st; stop = i_sp; sec_tick = i_tk; clear = i_clr;
    model_step();
    @(posedge clk);
    #1;
    check("minute",  int'(r_minute), m_total / 60);
    check("second",  int'(r_second), m_total % 60);
    check("running", int'(running),  (m_mode == M_RUN) ? 1 : 0);
    check("done",    int'(done),     m_done);
    check("alarm",   int'(alarm),    m_alarm);
  endtask

  task automatic idle_cyc();   cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tick_cyc();   cyc(0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic start_cyc();  cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic load_cyc(input int lm, input int ls); cyc(0, 1, lm, ls, 0, 0, 0, 0); endtask

  int done_cnt;
  int exp_alarm_const;

  initial begin
`ifdef TIMER_ALARM_EN
    exp_alarm_const = 1;
`else
    exp_alarm_const = 0;
`endif
    @(negedge clk);
    // Reset state.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_min", int'(r_minute), 0);
    idle_cyc();

    // Load 01:02, start, 62 ticks with a gap cycle now and then.
    load_cyc(1, 2);
    start_cyc();
    check("run_after_start", int'(running), 1);
    done_cnt = 0;
    for (int i = 1; i <= 62; i++) begin
      tick_cyc();
      done_cnt += int'(done);
      if (i == 2) check("s035_0100", int'(r_minute) * 60 + int'(r_second), 60);
      if (i == 3) check("s035_0059", int'(r_minute) * 100 + int'(r_second), 59);
      if (i == 62) check("s035_done_last", int'(done), 1);
      if (i % 7 == 0) idle_cyc();
    end
    check("s035_done_once", done_cnt, 1);
    check("s035_running", int'(running), 0);
    tick_cyc();
    check("no_wrap_sec", int'(r_second), 0);
    check("no_wrap_min", int'(r_minute), 0);

    // Pause/resume.
    load_cyc(0, 5);
    start_cyc();
    tick_cyc(); tick_cyc();
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    tick_cyc(); tick_cyc(); tick_cyc();
    check("s036_hold", int'(r_second), 3);
    start_cyc();
    tick_cyc(); tick_cyc(); tick_cyc();
    check("s036_zero", int'(r_second), 0);
    check("s036_done", int'(done), 1);

    // Clamping and zero-count start.
    load_cyc(63, 63);
    check("s037_min", int'(r_minute), 59);
    check("s037_sec", int'(r_second), 59);
    load_cyc(0, 0);
    start_cyc();
    check("s037_done", int'(done), 1);
    idle_cyc();
    check("s037_done_drop", int'(done), 0);

    // Stop and tick together, then load and start together.
    load_cyc(0, 10);
    start_cyc();
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    check("s038_hold", int'(r_second), 10);
    check("s038_paused", int'(running), 0);
    cyc(0, 1, 0, 20, 1, 0, 1, 0);
    check("s038_load_win", int'(r_second), 20);
    check("s038_idle", int'(running), 0);

    // Reset during the last decrement.
    load_cyc(0, 1);
    start_cyc();
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    check("s039_done", int'(done), 0);
    check("s039_sec", int'(r_second), 0);
    idle_cyc();

    // Alarm hold then clear.
    load_cyc(0, 1);
    start_cyc();
    tick_cyc();
    for (int i = 0; i < 100; i++) idle_cyc();
    check("s040_alarm_held", int'(alarm), exp_alarm_const);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("s040_alarm_clr", int'(alarm), 0);
    start_cyc();   // count 00:00 from IDLE -> expires again
    check("s040_reexpire", int'(done), 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r_r, r_l, r_s, r_p, r_t, r_c;
      int lm, ls;
      r_r = ($urandom_range(0, 199) == 0);
      r_l = ($urandom_range(0, 29) == 0);
      r_s = ($urandom_range(0, 9) == 0);
      r_p = ($urandom_range(0, 19) == 0);
      r_t = ($urandom_range(0, 1) == 0);
      r_c = ($urandom_range(0, 19) == 0);
      lm  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 1);
      ls  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12);
      cyc(r_r, r_l, lm, ls, r_s, r_p, r_t, r_c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
